// File: rtl/audio_pkg.sv
// Shared definitions for the DDS tone sequencer: note-word layout,
// end-marker value, FSM state encoding and field-extraction helpers.
package audio_pkg;

  localparam int DUR_MSB = 15;
  localparam int DUR_LSB = 10;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
  localparam int INC_W   = 10;

  // A note word whose duration field is zero terminates the melody.
  localparam logic [DUR_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  function automatic logic [DUR_W-1:0] note_dur(input logic [15:0] word);
    return word[DUR_MSB:DUR_LSB];
  endfunction

  function automatic logic [INC_W-1:0] note_inc(input logic [15:0] word);
    return word[INC_W-1:0];
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Control, note-ROM and DDS-side signals of the tone sequencer.
// master = surrounding system (tick source, controls, ROM), slave = sequencer.
interface tone_sequencer_if import audio_pkg::*; #(
  parameter int ADDR_W = 8
) ();

  logic              tick;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [INC_W-1:0]  phase_inc;
  logic              mute;
  logic              busy;
  logic              done;

  modport master (
    output tick, start, stop, loop_en, mem_data,
    input  mem_addr, phase_inc, mute, busy, done
  );

  modport slave (
    input  tick, start, stop, loop_en, mem_data,
    output mem_addr, phase_inc, mute, busy, done
  );

endinterface

// File: rtl/note_timer.sv
// Tick-driven down-counter pair that times notes and gaps.
// unit_cnt counts sample ticks within one unit, dur_cnt counts whole units.
// A gap is timed as a single unit whose tick count is the gap length.
module note_timer import audio_pkg::*; #(
  parameter int DUR_UNIT = 250,
  parameter int CNT_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] load_units,
  input  logic [CNT_W-1:0] load_ticks,
  input  logic             run,
  input  logic             tick,
  output logic             expire
);

  localparam logic [CNT_W-1:0] UNIT_RELOAD = CNT_W'(DUR_UNIT - 1);

  logic [CNT_W-1:0] unit_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             step;

  assign step   = run && tick;
  assign expire = step && (unit_cnt == '0) && (dur_cnt == DUR_W'(1));

  // Load a new interval, otherwise count down one tick at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_cnt <= '0;
      dur_cnt  <= '0;
    end else if (load) begin
      unit_cnt <= load_ticks;
      dur_cnt  <= load_units;
    end else if (step) begin
      if (unit_cnt == '0) begin
        unit_cnt <= UNIT_RELOAD;
        dur_cnt  <= dur_cnt - 1'b1;
      end else begin
        unit_cnt <= unit_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Melody controller for the DDS audio path: walks the note table in an
// external registered ROM, drives the phase increment per note and mutes
// the output during rests, inter-note gaps and while idle.
module tone_sequencer import audio_pkg::*; #(
  parameter int ADDR_W    = 8,
  parameter int DUR_UNIT  = 250,
  parameter int GAP_TICKS = 50
) (
  input logic            CLOCK_50,
  input logic            RESET_N,
  tone_sequencer_if.slave bus
);

  localparam int MAX_CNT = (DUR_UNIT > GAP_TICKS) ? DUR_UNIT : GAP_TICKS;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(DUR_UNIT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  =
    (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

  seq_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic [INC_W-1:0]  inc;
  logic              mute;
  logic              busy;
  logic              done;

  logic [DUR_W-1:0]  word_dur;
  logic [INC_W-1:0]  word_inc;
  logic              note_load;
  logic              gap_load;
  logic              timer_load;
  logic              timer_run;
  logic              expire;
  logic [DUR_W-1:0]  load_units;
  logic [CNT_W-1:0]  load_ticks;

  assign word_dur  = note_dur(bus.mem_data);
  assign word_inc  = note_inc(bus.mem_data);
  assign next_addr = addr + 1'b1;

  // The single timer is reloaded for a note in LATCH and for the gap when a note ends.
  assign note_load  = (state == LATCH) && (word_dur != END_MARKER);
  assign gap_load   = (state == PLAY) && expire && (GAP_TICKS > 0);
  assign timer_load = note_load || gap_load;
  assign timer_run  = (state == PLAY) || (state == GAP);
  assign load_units = note_load ? word_dur : DUR_W'(1);
  assign load_ticks = note_load ? UNIT_LOAD : GAP_LOAD;

  note_timer #(
    .DUR_UNIT (DUR_UNIT),
    .CNT_W    (CNT_W)
  ) timer (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .load       (timer_load),
    .load_units (load_units),
    .load_ticks (load_ticks),
    .run        (timer_run),
    .tick       (bus.tick),
    .expire     (expire)
  );

  // Sequencer FSM with registered outputs; stop overrides every transition.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      addr  <= '0;
      inc   <= '0;
      mute  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.stop) begin
        state <= IDLE;
        inc   <= '0;
        mute  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            inc  <= '0;
            mute <= 1'b1;
            if (bus.start) begin
              addr  <= '0;
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            if (word_dur == END_MARKER) begin
              if (bus.loop_en) begin
                addr  <= '0;
                state <= FETCH;
              end else begin
                inc   <= '0;
                mute  <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              inc   <= word_inc;
              mute  <= (word_inc == '0);
              state <= PLAY;
            end
          end
          PLAY: begin
            if (expire) begin
              if (GAP_TICKS > 0) begin
                mute  <= 1'b1;
                state <= GAP;
              end else begin
                addr  <= next_addr;
                state <= FETCH;
              end
            end
          end
          GAP: begin
            mute <= 1'b1;
            if (expire) begin
              addr  <= next_addr;
              state <= FETCH;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.phase_inc = inc;
  assign bus.mute      = mute;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer (DUR_UNIT=4, GAP_TICKS=2, tick every 8 clocks).
// Every change of {mem_addr, phase_inc, mute, busy, done} is an output event,
// tagged with the number of ticks the previous output value was held.
module tb_tone_sequencer;
  import audio_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int DUR_UNIT    = 4;
  localparam int GAP_TICKS   = 2;
  localparam int TICK_PERIOD = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [INC_W-1:0]  inc;
    logic              mute;
    logic              busy;
    logic              done;
    int                ticks;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   mon_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  obs_t  expq[$];
  string tagq[$];

  logic [15:0] rom [0:255];

  tone_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  tone_sequencer #(
    .ADDR_W    (ADDR_W),
    .DUR_UNIT  (DUR_UNIT),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  // 100 MHz-style bench clock
  always #5 clk = ~clk;

  // Registered note ROM: data follows the address one clock later
  always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

  function automatic logic [15:0] note(input int dur, input int inc);
    return {6'(dur), 10'(inc)};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.addr  = bus.mem_addr;
    o.inc   = bus.phase_inc;
    o.mute  = bus.mute;
    o.busy  = bus.busy;
    o.done  = bus.done;
    o.ticks = 0;
    return o;
  endfunction

  function automatic bit same_out(input obs_t x, input obs_t y);
    return (x.addr === y.addr) && (x.inc === y.inc) && (x.mute === y.mute) &&
           (x.busy === y.busy) && (x.done === y.done);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("addr=%0d inc=%0d mute=%b busy=%b done=%b ticks=%0d",
                     o.addr, o.inc, o.mute, o.busy, o.done, o.ticks);
  endfunction

  task automatic push_exp(input string tag, input int a, input int i,
                          input bit m, input bit b, input bit d, input int t);
    obs_t o;
    o.addr  = ADDR_W'(a);
    o.inc   = INC_W'(i);
    o.mute  = m;
    o.busy  = b;
    o.done  = d;
    o.ticks = t;
    expq.push_back(o);
    tagq.push_back(tag);
  endtask

  // Expected events for one complete pass over [{2,64},{0,0}] from idle.
  task automatic push_single_note_pass(input string p);
    push_exp({p, "_start"}, 0, 0,  1, 1, 0, -1);
    push_exp({p, "_note"},  0, 64, 0, 1, 0, 0);
    push_exp({p, "_gap"},   0, 64, 1, 1, 0, 8);
    push_exp({p, "_next"},  1, 64, 1, 1, 0, 2);
    push_exp({p, "_done"},  1, 0,  1, 1, 1, 0);
    push_exp({p, "_idle"},  1, 0,  1, 0, 0, 0);
  endtask

  task automatic load_table(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2);
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
  endtask

  // Returns just after the posedge at which a tick is sampled.
  task automatic sync_to_tick();
    do @(posedge clk); while (bus.tick !== 1'b1);
  endtask

  // One-cycle pulse on start and/or stop, driven on the falling edge.
  task automatic apply_stimulus(input bit do_start, input bit do_stop);
    @(negedge clk);
    bus.start = do_start;
    bus.stop  = do_stop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic check_output(input string tag, input int a, input int i,
                              input bit m, input bit b, input bit d);
    obs_t got;
    obs_t want;
    got        = sample();
    want.addr  = ADDR_W'(a);
    want.inc   = INC_W'(i);
    want.mute  = m;
    want.busy  = b;
    want.done  = d;
    want.ticks = 0;
    vectors++;
    if (!same_out(got, want)) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
    end
  endtask

  // Wait (bounded) until the monitor has consumed every expected event.
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && expq.size() != 0; i++) @(posedge clk);
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_drain: %0d expected events never seen, next is %s (%s)",
               tag, expq.size(), tagq[0], fmt(expq[0]));
      expq.delete();
      tagq.delete();
    end
    repeat (6) @(posedge clk);
  endtask

  // Tick source: one-cycle strobe every TICK_PERIOD clocks
  initial begin
    bus.tick = 1'b0;
    forever begin
      repeat (TICK_PERIOD - 1) @(negedge clk);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
    end
  end

  // Monitor: on every output change pop the next expectation and compare
  initial begin : monitor
    obs_t  cur;
    obs_t  prev;
    obs_t  want;
    string tag;
    int    ticks_seen;
    ticks_seen = 0;
    wait (mon_en);
    prev = sample();
    forever begin
      @(posedge clk);
      if (bus.tick === 1'b1) ticks_seen++;
      #1;
      cur = sample();
      if (!same_out(cur, prev)) begin
        cur.ticks  = ticks_seen;
        ticks_seen = 0;
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_event: got %s, required no change", fmt(cur));
        end else begin
          want = expq.pop_front();
          tag  = tagq.pop_front();
          if (!same_out(cur, want) || (want.ticks >= 0 && want.ticks != cur.ticks)) begin
            miscompares++;
            $display("[TB] FAIL %s: got %s, required %s", tag, fmt(cur), fmt(want));
          end
        end
        prev = cur;
      end
    end
  end

  // Overall time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Directed scenarios
  initial begin : main
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
    rst_n       = 1'b1;
    load_table(note(2, 64), note(0, 0), 16'h0000);

    #2 rst_n = 1'b0;
    #1 check_output("reset_values", 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("idle_after_reset", 0, 0, 1, 0, 0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] scenario 1: single note");
    push_single_note_pass("s1");
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    wait_drain("s1");

    $display("[TB] scenario 2: rest then note");
    load_table(note(1, 0), note(1, 100), note(0, 0));
    push_exp("s2_start", 0, 0,   1, 1, 0, -1);
    push_exp("s2_next",  1, 0,   1, 1, 0, 6);
    push_exp("s2_note",  1, 100, 0, 1, 0, 0);
    push_exp("s2_gap",   1, 100, 1, 1, 0, 4);
    push_exp("s2_next2", 2, 100, 1, 1, 0, 2);
    push_exp("s2_done",  2, 0,   1, 1, 1, 0);
    push_exp("s2_idle",  2, 0,   1, 0, 0, 0);
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    wait_drain("s2");

    $display("[TB] scenario 3: loop then natural end");
    load_table(note(2, 64), note(0, 0), 16'h0000);
    push_exp("s3_start", 0, 0,  1, 1, 0, -1);
    push_exp("s3_note",  0, 64, 0, 1, 0, 0);
    push_exp("s3_gap",   0, 64, 1, 1, 0, 8);
    push_exp("s3_next",  1, 64, 1, 1, 0, 2);
    push_exp("s3_loop",  0, 64, 1, 1, 0, 0);
    push_exp("s3_note2", 0, 64, 0, 1, 0, 0);
    push_exp("s3_gap2",  0, 64, 1, 1, 0, 8);
    push_exp("s3_next2", 1, 64, 1, 1, 0, 2);
    push_exp("s3_done",  1, 0,  1, 1, 1, 0);
    push_exp("s3_idle",  1, 0,  1, 0, 0, 0);
    bus.loop_en = 1'b1;
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    repeat (110) @(negedge clk);
    bus.loop_en = 1'b0;
    wait_drain("s3");

    $display("[TB] scenario 4: stop mid-note, then restart");
    push_exp("s4_start",   0, 0,  1, 1, 0, -1);
    push_exp("s4_note",    0, 64, 0, 1, 0, 0);
    push_exp("s4_stopped", 0, 0,  1, 0, 0, 3);
    push_exp("s4_restart", 0, 0,  1, 1, 0, 0);
    push_exp("s4_note2",   0, 64, 0, 1, 0, 0);
    push_exp("s4_gap",     0, 64, 1, 1, 0, 8);
    push_exp("s4_next",    1, 64, 1, 1, 0, 2);
    push_exp("s4_done",    1, 0,  1, 1, 1, 0);
    push_exp("s4_idle",    1, 0,  1, 0, 0, 0);
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    repeat (22) @(negedge clk);
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.stop  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("s4");

    $display("[TB] scenario 5: start+stop in idle, start during play");
    apply_stimulus(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 check_output("s5_idle_start_stop", 1, 0, 1, 0, 0);
    push_single_note_pass("s5");
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    apply_stimulus(1'b1, 1'b0);
    wait_drain("s5");

    $display("[TB] scenario 6: async reset during gap");
    push_exp("s6_start", 0, 0,  1, 1, 0, -1);
    push_exp("s6_note",  0, 64, 0, 1, 0, 0);
    push_exp("s6_gap",   0, 64, 1, 1, 0, 8);
    push_exp("s6_reset", 0, 0,  1, 0, 0, -1);
    push_single_note_pass("s6b");
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    repeat (69) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_output("s6_reset_immediate", 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sync_to_tick();
    apply_stimulus(1'b1, 1'b0);
    wait_drain("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
